// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard controller: tracks E/M/W producers, drives stall/bubble, forwarding selects and HI/LO busy interlock.
// Latency: stall and forwarding selects are combinational (zero-cycle) from D inputs; pipeline slots update one cycle later.
// Backpressure: a stall holds PC and F/D and injects a bubble into E; E/M forwarding keeps working while stalled.
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int TNEW_W      = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [TNEW_W-1:0] tuse_rs_d,
    input  logic [TNEW_W-1:0] tuse_rt_d,
    input  logic [REG_AW-1:0] dst_d,
    input  logic [TNEW_W-1:0] tnew_d,
    input  logic              md_start_d,
    input  logic              md_div_d,
    input  logic              md_use_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic [1:0]        fwd_rt_m,
    output logic              md_busy
);

    localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [REG_AW-1:0] e_rs, e_rt, e_dst;
    logic [TNEW_W-1:0] e_tnew;
    logic              e_md_start, e_md_div;
    logic [REG_AW-1:0] m_rt, m_dst;
    logic [TNEW_W-1:0] m_tnew;
    logic [REG_AW-1:0] w_dst;
    logic [CNT_W-1:0]  md_cnt;

    logic stall_rs, stall_rt, stall_md, stall;

    // Nearest producer wins; a producer still computing blocks older stages instead of falling through.
    function automatic logic [1:0] fwd_pick(
        input logic [REG_AW-1:0] a,
        input logic              chk_e,
        input logic [REG_AW-1:0] ed,
        input logic [TNEW_W-1:0] et,
        input logic [REG_AW-1:0] md,
        input logic [TNEW_W-1:0] mt,
        input logic [REG_AW-1:0] wd
    );
        fwd_pick = 2'd0;
        if (a != '0) begin
            if (chk_e && ed == a)
                fwd_pick = (et == '0) ? 2'd1 : 2'd0;
            else if (md == a)
                fwd_pick = (mt == '0) ? 2'd2 : 2'd0;
            else if (wd == a)
                fwd_pick = 2'd3;
        end
    endfunction

    assign md_busy  = (md_cnt != '0);

    assign stall_rs = (rs_d != '0) &&
                      ((e_dst == rs_d && e_tnew > tuse_rs_d) || (m_dst == rs_d && m_tnew > tuse_rs_d));
    assign stall_rt = (rt_d != '0) &&
                      ((e_dst == rt_d && e_tnew > tuse_rt_d) || (m_dst == rt_d && m_tnew > tuse_rt_d));
    assign stall_md = md_use_d && (e_md_start || md_busy);
    assign stall    = stall_rs || stall_rt || stall_md;

    assign stall_f  = stall;
    assign stall_d  = stall;
    assign flush_e  = stall;

    assign fwd_rs_d = fwd_pick(rs_d, 1'b1, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    assign fwd_rt_d = fwd_pick(rt_d, 1'b1, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    assign fwd_rs_e = fwd_pick(e_rs, 1'b0, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    assign fwd_rt_e = fwd_pick(e_rt, 1'b0, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    assign fwd_rt_m = (m_rt != '0 && w_dst == m_rt) ? 2'd3 : 2'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_rs       <= '0;
            e_rt       <= '0;
            e_dst      <= '0;
            e_tnew     <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_rt       <= '0;
            m_dst      <= '0;
            m_tnew     <= '0;
            w_dst      <= '0;
            md_cnt     <= '0;
        end else begin
            w_dst  <= m_dst;
            m_rt   <= e_rt;
            m_dst  <= e_dst;
            m_tnew <= (e_tnew != '0) ? e_tnew - TNEW_W'(1) : '0;

            if (stall) begin
                e_rs       <= '0;
                e_rt       <= '0;
                e_dst      <= '0;
                e_tnew     <= '0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_rs       <= rs_d;
                e_rt       <= rt_d;
                e_dst      <= dst_d;
                e_tnew     <= tnew_d;
                e_md_start <= md_start_d;
                e_md_div   <= md_start_d & md_div_d;
            end

            // Busy window opens the cycle after the md op sits in E.
            if (e_md_start)
                md_cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule
